load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the word-wide data memory interface. Accepts one CPU load/store request at a time
//  and drives word address, read enable and write enable. Byte and halfword stores are done as
//  read-modify-write; load data is extracted and extended. Sits between the MEM stage and data memory.
// PARAMETERS
//  N   10  word-address width (memory depth 2**N words)
//  M   32  data width (fixed 32; byte lanes assume 4 bytes/word)
// PORTS
//  clk          in   1    clock
//  rst          in   1    reset: synchronous, active-high
//  req_valid    in   1    request present
//  req_ready    out  1    unit can accept (1 only in IDLE)
//  req_we       in   1    1=store, 0=load
//  req_size     in   2    00=byte 01=half 10=word (11 treated as word)
//  req_unsigned in   1    loads: 1=zero-extend, 0=sign-extend
//  req_addr     in   32   byte address
//  req_wdata    in   32   store data (byte in [7:0], half in [15:0])
//  resp_valid   out  1    one-cycle completion pulse
//  resp_rdata   out  32   load result (0 for stores), valid with resp_valid
//  misalign_err out  1    valid with resp_valid; see CONFIGURATION
//  mem_addr     out  N    word address = req_addr[N+1:2]
//  mem_rd_en    out  1    memory read strobe
//  mem_rdata    in   M    memory read data, valid cycle after mem_rd_en
//  mem_wr_en    out  1    memory write strobe; memory commits during that cycle
//  mem_wdata    out  M    memory write data
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; resp_valid, mem_rd_en, mem_wr_en, misalign_err=0; resp_rdata,
//   mem_addr, mem_wdata=0. Reset in any state aborts the op: no strobe in cycle after reset, no resp.
//  Handshake: accept on req_valid&&req_ready at edge T; addr/size/data latched; inputs ignored after.
//  Big-endian lanes: byte offset 0=[31:24], 1=[23:16], 2=[15:8], 3=[7:0]; half offset 0=[31:16], 2=[15:0].
//  States: IDLE, RD, WAIT, WR, RESP.
//   IDLE -> WR (word store) | RD (load, sub-word store) | RESP (trapped misalign)
//   RD: mem_rd_en=1 -> WAIT. WAIT: sample mem_rdata; load: extract+extend to resp_rdata -> RESP;
//   sub-word store: merge req lane into word -> WR. WR: mem_wr_en=1 with merged/word data -> RESP.
//   RESP: resp_valid=1 one cycle -> IDLE (req_ready=1 next cycle; no back-to-back accept in RESP).
//  Latency (accept at T, resp_valid high in cycle): load T+3, word store T+2, sub-word store T+4.
//  Strobes are registered, never both high; mem_addr stable from RD/WR entry until IDLE.
//  Untouched lanes of a sub-word store keep the value read in WAIT (no intervening writer assumed).
//  req_addr bits above N+1 ignored (wrap to 2**N words).
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 issues no memory access;
//   resp_valid at T+1 with misalign_err=1, resp_rdata=0.
//  Not defined: offending low bits forced to 0 (half uses addr[1], word ignores [1:0]); misalign_err tied 0.
// TESTING
//  1 word store addr 0x10 data 0xDEADBEEF, then word load 0x10 -> mem word 4 = DEADBEEF, rdata 0xDEADBEEF at T+3.
//  2 word 4=0x11223344; sb addr 0x11 data 0xAA -> word 4=0x11AA3344, exactly one rd_en then one wr_en, resp T+4.
//  3 word 4=0x80FF7F01; lb 0x10 -> 0xFFFFFF80; lbu 0x10 -> 0x00000080; lh 0x12 -> 0x00007F01; lhu 0x10 -> 0x000080FF.
//  4 lw addr 0x13: with MISALIGN_TRAP_EN -> misalign_err=1, rdata=0, no strobes, resp T+1; without -> word 4 data.
//  5 rst asserted in WAIT of sb -> no mem_wr_en, no resp_valid; req_ready=1 cycle after reset; memory unchanged.
//  6 req_valid held high across op -> second request accepted only in IDLE after RESP; addr 0x1000 wraps to word 0 (N=10).

Source files
------------

// File: rtl/load_store_unit.sv
// Word-wide data memory initiator: loads, word stores, and sub-word stores via read-modify-write; one request in flight, req_ready only in IDLE.
// Latency accept->resp: load 3, word store 2, sub-word store 4; define MISALIGN_TRAP_EN to trap misaligned half/word accesses (resp after 1).
module load_store_unit #(
  parameter int N = 10,
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [1:0]   req_size,
  input  logic         req_unsigned,
  input  logic [31:0]  req_addr,
  input  logic [31:0]  req_wdata,
  output logic         resp_valid,
  output logic [31:0]  resp_rdata,
  output logic         misalign_err,
  output logic [N-1:0] mem_addr,
  output logic         mem_rd_en,
  input  logic [M-1:0] mem_rdata,
  output logic         mem_wr_en,
  output logic [M-1:0] mem_wdata
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] RESP = 3'd4;

  logic [2:0]   state_q, state_d;
  logic [N-1:0] addr_q, addr_d;
  logic [1:0]   off_q, off_d;
  logic [1:0]   size_q, size_d;
  logic         we_q, we_d;
  logic         uns_q, uns_d;
  logic [31:0]  wdata_q, wdata_d;
  logic [31:0]  rdata_q, rdata_d;
  logic [M-1:0] mwdata_q, mwdata_d;
  logic         rd_en_q, wr_en_q, resp_q;

  logic         accept;
  logic         trap;
  logic [1:0]   eff_size;
  logic [1:0]   eff_off;
  logic         unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:N+2];

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                          input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (sz)
      2'b00:   extract = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   extract = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: extract = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                        input logic [1:0] sz, input logic [1:0] off);
    merge = w;
    if (sz == 2'b00) begin
      case (off)
        2'd0:    merge[31:24] = d[7:0];
        2'd1:    merge[23:16] = d[7:0];
        2'd2:    merge[15:8]  = d[7:0];
        default: merge[7:0]   = d[7:0];
      endcase
    end else if (sz == 2'b01) begin
      if (off[1]) merge[15:0] = d[15:0];
      else        merge[31:16] = d[15:0];
    end else begin
      merge = d;
    end
  endfunction

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign eff_size  = (req_size == 2'b11) ? 2'b10 : req_size;
  // Misaligned low bits are dropped here; in trap builds those requests never reach memory anyway.
  assign eff_off   = (eff_size == 2'b00) ? req_addr[1:0] :
                     (eff_size == 2'b01) ? {req_addr[1], 1'b0} : 2'b00;

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;
  assign trap = ((eff_size == 2'b01) && req_addr[0]) ||
                ((eff_size == 2'b10) && (req_addr[1:0] != 2'b00));
  always_ff @(posedge clk) begin
    if (rst)                  misalign_q <= 1'b0;
    else if (accept)          misalign_q <= trap;
    else if (state_q == RESP) misalign_q <= 1'b0;
  end
  assign misalign_err = misalign_q;
`else
  assign trap         = 1'b0;
  assign misalign_err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    off_d    = off_q;
    size_d   = size_q;
    we_d     = we_q;
    uns_d    = uns_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    mwdata_d = mwdata_q;
    case (state_q)
      IDLE: if (accept) begin
        addr_d  = req_addr[N+1:2];
        off_d   = eff_off;
        size_d  = eff_size;
        we_d    = req_we;
        uns_d   = req_unsigned;
        wdata_d = req_wdata;
        rdata_d = 32'b0;
        if (trap) begin
          state_d = RESP;
        end else if (req_we && eff_size == 2'b10) begin
          mwdata_d = req_wdata;
          state_d  = WR;
        end else begin
          state_d = RD;
        end
      end
      RD:   state_d = WAIT;
      WAIT: begin
        if (we_q) begin
          mwdata_d = merge(mem_rdata, wdata_q, size_q, off_q);
          state_d  = WR;
        end else begin
          rdata_d = extract(mem_rdata, size_q, off_q, uns_q);
          state_d = RESP;
        end
      end
      WR:      state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      off_q    <= 2'b0;
      size_q   <= 2'b0;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      wdata_q  <= 32'b0;
      rdata_q  <= 32'b0;
      mwdata_q <= '0;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      resp_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      off_q    <= off_d;
      size_q   <= size_d;
      we_q     <= we_d;
      uns_q    <= uns_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      mwdata_q <= mwdata_d;
      rd_en_q  <= (state_d == RD);
      wr_en_q  <= (state_d == WR);
      resp_q   <= (state_d == RESP);
    end
  end

  assign resp_valid = resp_q;
  assign resp_rdata = rdata_q;
  assign mem_addr   = addr_q;
  assign mem_rd_en  = rd_en_q;
  assign mem_wr_en  = wr_en_q;
  assign mem_wdata  = mwdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed table of load/store requests against a behavioural word memory, plus reset-abort and held-valid sequences.
module tb_load_store_unit;

  localparam int N = 10;
  localparam int M = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [1:0]   req_size;
  logic         req_unsigned;
  logic [31:0]  req_addr;
  logic [31:0]  req_wdata;
  logic         resp_valid;
  logic [31:0]  resp_rdata;
  logic         misalign_err;
  logic [N-1:0] mem_addr;
  logic         mem_rd_en;
  logic [M-1:0] mem_rdata;
  logic         mem_wr_en;
  logic [M-1:0] mem_wdata;

  logic [31:0] mem [0:(1<<N)-1];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_store_unit #(.N(N), .M(M)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .misalign_err(misalign_err),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata)
  );

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic        exp_mis;
    int          mem_idx;
    logic [31:0] mem_val;
  } vec_t;

  vec_t v[18];

  function automatic vec_t mk(logic we, logic [1:0] size, logic uns, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] exp_rdata, int lat, int rd,
                              int wr, logic mis, int idx, logic [31:0] mval);
    vec_t t;
    t.we = we; t.size = size; t.uns = uns; t.addr = addr; t.wdata = wdata;
    t.exp_rdata = exp_rdata; t.exp_lat = lat; t.exp_rd = rd; t.exp_wr = wr;
    t.exp_mis = mis; t.mem_idx = idx; t.mem_val = mval;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t t, input string tag);
    int lat = 99;
    int rd = 0;
    int wr = 0;
    logic [31:0] rdata = 32'hx;
    logic mis = 1'bx;
    @(negedge clk);
    chk({tag, " ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = t.we; req_size = t.size; req_unsigned = t.uns;
    req_addr = t.addr; req_wdata = t.wdata;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
      rd += int'(mem_rd_en);
      wr += int'(mem_wr_en);
      if (resp_valid) begin
        lat = c; rdata = resp_rdata; mis = misalign_err;
        break;
      end
    end
    chk({tag, " latency"}, lat, t.exp_lat);
    chk({tag, " rdata"}, rdata, t.exp_rdata);
    chk({tag, " misalign"}, {31'b0, mis}, {31'b0, t.exp_mis});
    chk({tag, " rd_strobes"}, rd, t.exp_rd);
    chk({tag, " wr_strobes"}, wr, t.exp_wr);
    @(negedge clk);
    chk({tag, " mem word"}, mem[t.mem_idx], t.mem_val);
  endtask

  initial begin
    int wr;
    int rsp;
    logic [31:0] first_rdata;
    for (int i = 0; i < (1<<N); i++) mem[i] = 32'h0;
    mem_rdata = '0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("reset strobes", {30'b0, mem_rd_en, mem_wr_en}, 32'd0);
    chk("reset misalign", {31'b0, misalign_err}, 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'd0);
    chk("reset mem_addr", {22'b0, mem_addr}, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);

    v[0]  = mk(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0,        2, 0, 1, 0, 4, 32'hDEADBEEF);
    v[1]  = mk(0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 3, 1, 0, 0, 4, 32'hDEADBEEF);
    v[2]  = mk(1, 2'b10, 0, 32'h10, 32'h11223344, 32'h0,        2, 0, 1, 0, 4, 32'h11223344);
    v[3]  = mk(1, 2'b00, 0, 32'h11, 32'h000000AA, 32'h0,        4, 1, 1, 0, 4, 32'h11AA3344);
    v[4]  = mk(0, 2'b11, 0, 32'h10, 32'h0,        32'h11AA3344, 3, 1, 0, 0, 4, 32'h11AA3344);
    v[5]  = mk(1, 2'b10, 0, 32'h10, 32'h80FF7F01, 32'h0,        2, 0, 1, 0, 4, 32'h80FF7F01);
    v[6]  = mk(0, 2'b00, 0, 32'h10, 32'h0,        32'hFFFFFF80, 3, 1, 0, 0, 4, 32'h80FF7F01);
    v[7]  = mk(0, 2'b00, 1, 32'h10, 32'h0,        32'h00000080, 3, 1, 0, 0, 4, 32'h80FF7F01);
    v[8]  = mk(0, 2'b01, 0, 32'h12, 32'h0,        32'h00007F01, 3, 1, 0, 0, 4, 32'h80FF7F01);
    v[9]  = mk(0, 2'b01, 1, 32'h10, 32'h0,        32'h000080FF, 3, 1, 0, 0, 4, 32'h80FF7F01);
    v[10] = mk(0, 2'b00, 0, 32'h13, 32'h0,        32'h00000001, 3, 1, 0, 0, 4, 32'h80FF7F01);
    v[11] = mk(0, 2'b01, 0, 32'h10, 32'h0,        32'hFFFF80FF, 3, 1, 0, 0, 4, 32'h80FF7F01);
    v[12] = mk(1, 2'b01, 0, 32'h12, 32'hFFFFBEEF, 32'h0,        4, 1, 1, 0, 4, 32'h80FFBEEF);
`ifdef MISALIGN_TRAP_EN
    v[13] = mk(0, 2'b10, 0, 32'h13, 32'h0,        32'h0,        1, 0, 0, 1, 4, 32'h80FFBEEF);
    v[14] = mk(0, 2'b01, 0, 32'h11, 32'h0,        32'h0,        1, 0, 0, 1, 4, 32'h80FFBEEF);
`else
    v[13] = mk(0, 2'b10, 0, 32'h13, 32'h0,        32'h80FFBEEF, 3, 1, 0, 0, 4, 32'h80FFBEEF);
    v[14] = mk(0, 2'b01, 0, 32'h11, 32'h0,        32'hFFFF80FF, 3, 1, 0, 0, 4, 32'h80FFBEEF);
`endif
    v[15] = mk(1, 2'b10, 0, 32'h1000, 32'h12345678, 32'h0,      2, 0, 1, 0, 0, 32'h12345678);
    v[16] = mk(0, 2'b10, 0, 32'h0,  32'h0,        32'h12345678, 3, 1, 0, 0, 0, 32'h12345678);
    v[17] = mk(1, 2'b00, 0, 32'h3,  32'h000001CC, 32'h0,        4, 1, 1, 0, 0, 32'h123456CC);

    for (int i = 0; i < 18; i++) run_op(v[i], $sformatf("v%0d", i));

    // Reset while a byte store sits in WAIT must abort before the write.
    run_op(mk(1, 2'b10, 0, 32'h10, 32'h11223344, 32'h0, 2, 0, 1, 0, 4, 32'h11223344), "rst_setup");
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h11; req_wdata = 32'h00000055;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort req_ready", {31'b0, req_ready}, 32'd1);
    wr = 0; rsp = 0;
    for (int c = 0; c < 6; c++) begin
      wr += int'(mem_wr_en);
      rsp += int'(resp_valid);
      @(negedge clk);
    end
    chk("abort wr_strobes", wr, 0);
    chk("abort resp", rsp, 0);
    chk("abort mem word", mem[4], 32'h11223344);

    // Held req_valid: second request (wrapping to word 0) is taken only after RESP.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clk);
    first_rdata = 32'hx;
    rsp = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) req_addr = 32'h1000;
      if (c <= 3) chk($sformatf("held ready c%0d", c), {31'b0, req_ready}, 32'd0);
      if (c == 3) chk("held resp1 rdata", resp_valid ? resp_rdata : 32'hBAD0BAD0, 32'h11223344);
      if (c == 4) chk("held ready idle", {31'b0, req_ready}, 32'd1);
      if (c == 5) chk("held wrap mem_addr", {22'b0, mem_addr}, 32'd0);
      if (c == 7) chk("held resp2 rdata", resp_valid ? resp_rdata : 32'hBAD0BAD0, 32'h123456CC);
      rsp += int'(resp_valid);
      if (c == 7) req_valid = 1'b0;
    end
    chk("held resp count", rsp, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
